shift_tx_sched: RTL and testbench

//  Shares one 7-bit parallel-in/serial-out shift datapath between two requesters.

---
 rtl/shift_tx_pkg.sv | 25 ++
 rtl/shift_tx_sched_if.sv | 31 +++
 rtl/shift_tx_core.sv | 37 +++
 rtl/shift_tx_sched.sv | 113 +++++++++++
 tb/tb_shift_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_tx_pkg.sv
// Shared types and sizing helpers for the shift_tx_sched serializer.
// TX_PARITY_EN adds an even-parity bit after the MSB of every frame.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  // Bits on the wire per frame, including the optional parity bit.
  function automatic int calc_nbits(input int width);
`ifdef TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_tx_sched_if.sv
// Requester/serial-line bundle for shift_tx_sched; slave = scheduler, master = producers/sink.
// Handshake: a word moves on a rising edge where vldN & rdyN are both high; rdyN never depends on a later cycle.
interface shift_tx_sched_if #(
  parameter int WIDTH = 7
);
  import shift_tx_pkg::*;

  logic [WIDTH-1:0] din0;
  logic             vld0;
  logic             rdy0;
  logic [WIDTH-1:0] din1;
  logic             vld1;
  logic             rdy1;
  logic             dout;
  logic             dout_vld;
  logic             busy;
  logic             done;
  logic             gnt_id;
  state_t           state;

  modport master (
    output din0, vld0, din1, vld1,
    input  rdy0, rdy1, dout, dout_vld, busy, done, gnt_id, state
  );

  modport slave (
    input  din0, vld0, din1, vld1,
    output rdy0, rdy1, dout, dout_vld, busy, done, gnt_id, state
  );

endinterface

// File: rtl/shift_tx_core.sv
// Parallel-in/serial-out shift register, LSB first; parity bit (TX_PARITY_EN) sits above the MSB.
module shift_tx_core
  import shift_tx_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit0
);
  localparam int NBITS = calc_nbits(WIDTH);

  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load_val;

`ifdef TX_PARITY_EN
  assign load_val = {^din, din};
`else
  assign load_val = din;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_val;
    end else if (shift) begin
      shreg <= {1'b0, shreg[NBITS-1:1]};
    end
  end

  assign bit0 = shreg[0];

endmodule

// File: rtl/shift_tx_sched.sv
// Two-requester round-robin scheduler feeding one serial line; FSM IDLE -> SHIFT -> GAPW -> IDLE.
// Build with TX_PARITY_EN to append an even-parity bit to every frame.
module shift_tx_sched
  import shift_tx_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DIV   = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  shift_tx_sched_if.slave  bus
);
  localparam int NBITS   = calc_nbits(WIDTH);
  localparam int TICK_W  = cnt_w(DIV);
  localparam int BIT_W   = cnt_w(NBITS);
  localparam int GAP_CYC = GAP * DIV;
  localparam int GAP_W   = cnt_w(GAP_CYC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q;
  logic [BIT_W-1:0]  bit_q;
  logic [GAP_W-1:0]  gap_q;
  logic              gnt_id_q;
  logic              last_q;
  logic              done_q;

  logic grant0, grant1;
  logic rdy0, rdy1, load, tick_wrap, last_bit;
  logic bit0;

  // With both requesters waiting, the one not served last time wins.
  assign grant0 = bus.vld0 & (~bus.vld1 | last_q);
  assign grant1 = bus.vld1 & (~bus.vld0 | ~last_q);

  always_comb begin
    state_d   = state_q;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    load      = 1'b0;
    tick_wrap = 1'b0;
    last_bit  = 1'b0;
    case (state_q)
      IDLE: begin
        rdy0 = grant0;
        rdy1 = grant1;
        load = grant0 | grant1;
        if (load) state_d = SHIFT;
      end
      SHIFT: begin
        tick_wrap = (tick_q == TICK_LAST);
        last_bit  = tick_wrap & (bit_q == BIT_LAST);
        if (last_bit) state_d = (GAP > 0) ? GAPW : IDLE;
      end
      GAPW: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      gnt_id_q <= 1'b0;
      last_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_bit;
      if (load) begin
        gnt_id_q <= grant1;
        last_q   <= grant1;
        tick_q   <= '0;
        bit_q    <= '0;
      end else if (state_q == SHIFT) begin
        if (tick_wrap) begin
          tick_q <= '0;
          bit_q  <= bit_q + 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
      if (state_q == GAPW) gap_q <= gap_q + 1'b1;
      else                 gap_q <= '0;
    end
  end

  shift_tx_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (tick_wrap),
    .din   (grant1 ? bus.din1 : bus.din0),
    .bit0  (bit0)
  );

  assign bus.rdy0     = rdy0;
  assign bus.rdy1     = rdy1;
  assign bus.dout     = (state_q == SHIFT) & bit0;
  assign bus.dout_vld = (state_q == SHIFT);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_shift_tx_sched.sv
// Bench for shift_tx_sched: instance a (DIV=4, GAP=1) and instance b (DIV=1, GAP=0).
// Expected frames are queued at each handshake and popped as frames leave the serial line.
module tb_shift_tx_sched;
  import shift_tx_pkg::*;

  localparam int DIV_A  = 4;
  localparam int GAP_A  = 1;
`ifdef TX_PARITY_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  localparam int PERIOD = NB * DIV_A + GAP_A * DIV_A + 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [NB:0] exp_q[$];
  logic [NB:0] exp_b_q[$];

  shift_tx_sched_if #(.WIDTH(7)) a_if ();
  shift_tx_sched_if #(.WIDTH(7)) b_if ();

  shift_tx_sched #(.WIDTH(7), .DIV(DIV_A), .GAP(GAP_A)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  shift_tx_sched #(.WIDTH(7), .DIV(1), .GAP(0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1);
  end

  // Model of one frame: {owner id, wire bits LSB first}.
  function automatic logic [NB:0] frame_of(input logic id, input logic [6:0] d);
`ifdef TX_PARITY_EN
    return {id, ^d, d};
`else
    return {id, d};
`endif
  endfunction

  // Scoreboard push: the requester whose vld&rdy is high at the edge owns the next frame.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (a_if.vld0 === 1'b1 && a_if.rdy0 === 1'b1) exp_q.push_back(frame_of(1'b0, a_if.din0));
      else if (a_if.vld1 === 1'b1 && a_if.rdy1 === 1'b1) exp_q.push_back(frame_of(1'b1, a_if.din1));
      if (b_if.vld0 === 1'b1 && b_if.rdy0 === 1'b1) exp_b_q.push_back(frame_of(1'b0, b_if.din0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    a_if.vld0 = 1'b0; a_if.vld1 = 1'b0; b_if.vld0 = 1'b0; b_if.vld1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_b_q.delete();
  endtask

  // Offers one word on instance a; returns at the negedge of the first frame bit with vld dropped.
  task automatic send_word_a(input logic id, input logic [6:0] d, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    if (id) begin a_if.din1 = d; a_if.vld1 = 1'b1; end
    else    begin a_if.din0 = d; a_if.vld0 = 1'b1; end
    #1;
    while (((id ? a_if.rdy1 : a_if.rdy0) !== 1'b1) && w < 100) begin
      @(negedge clk); #1; w++;
    end
    ok = (w < 100);
    @(negedge clk);
    if (id) a_if.vld1 = 1'b0;
    else    a_if.vld0 = 1'b0;
  endtask

  // Collects one frame from instance a; sampling the first clock of each bit.
  task automatic capture_a(output logic [NB-1:0] bits, output int len,
                           output logic done_seen, output logic id_seen, output bit ok);
    int w;
    bits = '0; len = 0; done_seen = 1'b0; id_seen = 1'b0; ok = 1'b0; w = 0;
    while (a_if.dout_vld !== 1'b1 && w < 400) begin @(negedge clk); w++; end
    if (a_if.dout_vld !== 1'b1) return;
    id_seen = a_if.gnt_id;
    while (a_if.dout_vld === 1'b1 && len < 400) begin
      if ((len % DIV_A) == 0 && (len / DIV_A) < NB) bits[len / DIV_A] = a_if.dout;
      len++;
      @(negedge clk);
    end
    done_seen = a_if.done;
    ok = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (a_if.state !== IDLE) $display("FAIL rst_state: got %0d exp %0d", a_if.state, IDLE); else n_pass++;
    n_checks++; if (a_if.dout_vld !== 1'b0) $display("FAIL rst_dout_vld: got %b exp 0", a_if.dout_vld); else n_pass++;
    n_checks++; if (a_if.dout !== 1'b0) $display("FAIL rst_dout: got %b exp 0", a_if.dout); else n_pass++;
    n_checks++; if (a_if.busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", a_if.busy); else n_pass++;
    n_checks++; if (a_if.done !== 1'b0) $display("FAIL rst_done: got %b exp 0", a_if.done); else n_pass++;
    n_checks++; if (a_if.gnt_id !== 1'b0) $display("FAIL rst_gnt_id: got %b exp 0", a_if.gnt_id); else n_pass++;
    n_checks++; if (b_if.busy !== 1'b0) $display("FAIL rst_b_busy: got %b exp 0", b_if.busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [NB:0] e;
    int bad;
    do_reset();
    @(negedge clk); a_if.din0 = 7'h55; a_if.vld0 = 1'b1; #1;
    n_checks++; if (a_if.rdy0 !== 1'b1) $display("FAIL single_rdy0: got %b exp 1", a_if.rdy0); else n_pass++;
    n_checks++; if (a_if.rdy1 !== 1'b0) $display("FAIL single_rdy1: got %b exp 0", a_if.rdy1); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (a_if.rdy0 !== 1'b0) $display("FAIL single_rdy_once: got %b exp 0", a_if.rdy0); else n_pass++;
    a_if.vld0 = 1'b0;
    n_checks++; if (exp_q.size() !== 1) $display("FAIL single_queue: got %0d exp 1", exp_q.size()); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    bad = 0;
    for (int k = 1; k <= NB * DIV_A; k++) begin
      if (a_if.dout_vld !== 1'b1 || a_if.dout !== e[(k - 1) / DIV_A]) bad++;
      @(negedge clk); #1;
    end
    n_checks++; if (bad !== 0) $display("FAIL single_bits: got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if (a_if.done !== 1'b1) $display("FAIL single_done_cycle: got %b exp 1", a_if.done); else n_pass++;
    n_checks++; if (a_if.dout_vld !== 1'b0) $display("FAIL single_vld_end: got %b exp 0", a_if.dout_vld); else n_pass++;
    n_checks++; if (a_if.gnt_id !== 1'b0) $display("FAIL single_gnt_id: got %b exp 0", a_if.gnt_id); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (a_if.done !== 1'b0) $display("FAIL single_done_pulse: got %b exp 0", a_if.done); else n_pass++;
  endtask

  task automatic test_words();
    logic [6:0] words[4];
    logic ids[4];
    logic [NB-1:0] bits;
    logic [NB:0] e;
    logic dn, idv;
    int len;
    bit ok;
    words[0] = 7'h07; words[1] = 7'h03;
    words[2] = 7'($urandom_range(0, 127)); words[3] = 7'($urandom_range(0, 127));
    ids[0] = 1'b0; ids[1] = 1'b0; ids[2] = 1'b1; ids[3] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      send_word_a(ids[i], words[i], ok);
      n_checks++; if (!ok) $display("FAIL words_handshake[%0d]: got timeout exp rdy", i); else n_pass++;
      capture_a(bits, len, dn, idv, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++; if (bits !== e[NB-1:0]) $display("FAIL words_bits[%0d]: got %h exp %h", i, bits, e[NB-1:0]); else n_pass++;
      n_checks++; if (len !== NB * DIV_A) $display("FAIL words_len[%0d]: got %0d exp %0d", i, len, NB * DIV_A); else n_pass++;
      n_checks++; if (dn !== 1'b1) $display("FAIL words_done[%0d]: got %b exp 1", i, dn); else n_pass++;
      n_checks++; if (idv !== ids[i]) $display("FAIL words_gnt_id[%0d]: got %b exp %b", i, idv, ids[i]); else n_pass++;
    end
  endtask

  task automatic test_contention();
    logic [NB-1:0] bits;
    logic [NB:0] e;
    logic dn, idv, exp_id;
    int len;
    bit ok;
    do_reset();
    @(negedge clk);
    a_if.din0 = 7'h01; a_if.din1 = 7'h7E; a_if.vld0 = 1'b1; a_if.vld1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = ((i % 2) != 0);
      capture_a(bits, len, dn, idv, ok);
      n_checks++; if (!ok || exp_q.size() == 0) $display("FAIL cont_frame[%0d]: got ok=%0d q=%0d exp frame", i, ok, exp_q.size()); else n_pass++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++; if (e[NB] !== exp_id) $display("FAIL cont_order[%0d]: got req%b exp req%b", i, e[NB], exp_id); else n_pass++;
      n_checks++; if (bits !== e[NB-1:0]) $display("FAIL cont_bits[%0d]: got %h exp %h", i, bits, e[NB-1:0]); else n_pass++;
      n_checks++; if (idv !== exp_id) $display("FAIL cont_gnt_id[%0d]: got %b exp %b", i, idv, exp_id); else n_pass++;
    end
    a_if.vld0 = 1'b0; a_if.vld1 = 1'b0;
    repeat (PERIOD + 4) @(negedge clk);
    n_checks++; if (exp_q.size() !== 0) $display("FAIL cont_queue_empty: got %0d exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int last_hs, hs_cnt, low_run;
    bit prev_hs, seen_frame;
    do_reset();
    last_hs = -1; hs_cnt = 0; low_run = 0; prev_hs = 1'b0; seen_frame = 1'b0;
    for (int c = 0; c <= 4 * PERIOD; c++) begin
      @(negedge clk);
      if (c == 0 || prev_hs) a_if.din1 = 7'($urandom_range(0, 127));
      if (c == 0) a_if.vld1 = 1'b1;
      #1;
      prev_hs = (a_if.vld1 === 1'b1 && a_if.rdy1 === 1'b1);
      if (prev_hs) begin
        if (last_hs >= 0) begin
          n_checks++; if (c - last_hs !== PERIOD) $display("FAIL b2b_period: got %0d exp %0d", c - last_hs, PERIOD); else n_pass++;
        end
        last_hs = c;
        hs_cnt++;
      end
      if (a_if.dout_vld === 1'b1) begin
        if (seen_frame && low_run > 0) begin
          n_checks++; if (low_run !== GAP_A * DIV_A + 1) $display("FAIL b2b_gap: got %0d exp %0d", low_run, GAP_A * DIV_A + 1); else n_pass++;
        end
        low_run = 0;
        seen_frame = 1'b1;
      end else if (seen_frame) begin
        low_run++;
      end
    end
    n_checks++; if (hs_cnt !== 5) $display("FAIL b2b_count: got %0d exp 5", hs_cnt); else n_pass++;
    @(negedge clk); a_if.vld1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] bits;
    logic [NB:0] e;
    logic dn, idv, any_done;
    int len;
    bit ok;
    do_reset();
    send_word_a(1'b0, 7'h7F, ok);
    n_checks++; if (!ok) $display("FAIL rmid_handshake: got timeout exp rdy"); else n_pass++;
    repeat (3 * DIV_A + 1) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (a_if.dout_vld !== 1'b0) $display("FAIL rmid_dout_vld: got %b exp 0", a_if.dout_vld); else n_pass++;
    n_checks++; if (a_if.dout !== 1'b0) $display("FAIL rmid_dout: got %b exp 0", a_if.dout); else n_pass++;
    n_checks++; if (a_if.busy !== 1'b0) $display("FAIL rmid_busy: got %b exp 0", a_if.busy); else n_pass++;
    n_checks++; if (a_if.state !== IDLE) $display("FAIL rmid_state: got %0d exp %0d", a_if.state, IDLE); else n_pass++;
    any_done = 1'b0;
    repeat (3) begin @(negedge clk); any_done |= a_if.done; end
    rst = 1'b1;
    exp_q.delete();
    repeat (NB * DIV_A + GAP_A * DIV_A + 4) begin @(negedge clk); #1; any_done |= a_if.done; end
    n_checks++; if (any_done !== 1'b0) $display("FAIL rmid_no_done: got %b exp 0", any_done); else n_pass++;
    @(negedge clk);
    a_if.din0 = 7'($urandom_range(0, 127)); a_if.din1 = 7'($urandom_range(0, 127));
    a_if.vld0 = 1'b1; a_if.vld1 = 1'b1;
    #1;
    n_checks++; if (a_if.rdy0 !== 1'b1) $display("FAIL rmid_rdy0: got %b exp 1", a_if.rdy0); else n_pass++;
    n_checks++; if (a_if.rdy1 !== 1'b0) $display("FAIL rmid_rdy1: got %b exp 0", a_if.rdy1); else n_pass++;
    @(negedge clk); a_if.vld0 = 1'b0; a_if.vld1 = 1'b0;
    capture_a(bits, len, dn, idv, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++; if (bits !== e[NB-1:0]) $display("FAIL rmid_bits: got %h exp %h", bits, e[NB-1:0]); else n_pass++;
    n_checks++; if (idv !== 1'b0) $display("FAIL rmid_gnt_id: got %b exp 0", idv); else n_pass++;
  endtask

  task automatic test_div1();
    logic [NB:0] e;
    int bad;
    do_reset();
    @(negedge clk); b_if.din0 = 7'h2A; b_if.vld0 = 1'b1; #1;
    n_checks++; if (b_if.rdy0 !== 1'b1) $display("FAIL div1_rdy0: got %b exp 1", b_if.rdy0); else n_pass++;
    @(negedge clk); b_if.vld0 = 1'b0; #1;
    e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 'x;
    bad = 0;
    for (int k = 1; k <= NB; k++) begin
      if (b_if.dout_vld !== 1'b1 || b_if.dout !== e[k - 1]) bad++;
      if (k == NB) begin
        n_checks++; if (b_if.busy !== 1'b1) $display("FAIL div1_busy_last: got %b exp 1", b_if.busy); else n_pass++;
      end
      @(negedge clk); #1;
    end
    n_checks++; if (bad !== 0) $display("FAIL div1_bits: got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if (b_if.done !== 1'b1) $display("FAIL div1_done: got %b exp 1", b_if.done); else n_pass++;
    n_checks++; if (b_if.dout_vld !== 1'b0) $display("FAIL div1_vld_end: got %b exp 0", b_if.dout_vld); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (b_if.busy !== 1'b0) $display("FAIL div1_busy_after: got %b exp 0", b_if.busy); else n_pass++;
    n_checks++; if (b_if.done !== 1'b0) $display("FAIL div1_done_pulse: got %b exp 0", b_if.done); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    a_if.din0 = '0; a_if.din1 = '0; a_if.vld0 = 1'b0; a_if.vld1 = 1'b0;
    b_if.din0 = '0; b_if.din1 = '0; b_if.vld0 = 1'b0; b_if.vld1 = 1'b0;
    test_reset();
    test_single();
    test_words();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
